// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU state/error enums, decode helpers.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FIN  = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_ILLEGAL  = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } lsu_err_t;

    // Stores only have B/H/W; loads additionally have the unsigned BU/HU forms.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] ea_lo);
        logic mis;
        case (f3)
            F3_H, F3_HU: mis = ea_lo[0];
            F3_W:        mis = (ea_lo != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication and strobes, load byte/half extraction and extension.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  ea_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    assign byte_c = 8'(rdata >> {ea_lo, 3'b000});
    assign half_c = ea_lo[1] ? rdata[31:16] : rdata[15:0];

    // Lane selection per access width; unused widths drive zeros.
    always_comb begin
        wdata     = 32'h0;
        wstrb     = 4'b0000;
        load_data = 32'h0;
        case (funct3)
            F3_B: begin
                wdata     = {4{store_data[7:0]}};
                wstrb     = 4'b0001 << ea_lo;
                load_data = {{24{byte_c[7]}}, byte_c};
            end
            F3_H: begin
                wdata     = {2{store_data[15:0]}};
                wstrb     = 4'b0011 << ea_lo;
                load_data = {{16{half_c[15]}}, half_c};
            end
            F3_W: begin
                wdata     = store_data;
                wstrb     = 4'b1111;
                load_data = rdata;
            end
            F3_BU:   load_data = {24'h0, byte_c};
            F3_HU:   load_data = {16'h0, half_c};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store executor: FSM, latched op fields, bus timeout, register writeback.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_cause,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        reg_write_control,
    output logic [4:0]  reg_write_select,
    output logic [31:0] reg_write_data
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    lsu_state_t  state_q, state_d;
    logic [31:0] ea_q, sdata_q;
    logic [2:0]  f3_q;
    logic        st_q;
    logic [4:0]  rd_q;
    logic [31:0] ea_c;
    logic        latch_c;
    logic        to_hit_c;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    lsu_err_t    cause_q, cause_d;
    logic        req_q, req_d;
    logic        wr_q, wr_d;
    logic [4:0]  wsel_q, wsel_d;
    logic [31:0] wdat_q, wdat_d;

    logic [31:0] al_wdata, al_load;
    logic [3:0]  al_wstrb;

    assign ea_c = base + offset;

    lsu_align u_align (
        .funct3     (f3_q),
        .ea_lo      (ea_q[1:0]),
        .store_data (sdata_q),
        .rdata      (mem_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_data  (al_load)
    );

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            logic [CW-1:0] cnt_q;

            // Count consecutive REQ cycles without a bus response.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else if (state_q == REQ && !mem_ready) begin
                    cnt_q <= cnt_q + CW'(1);
                end else begin
                    cnt_q <= '0;
                end
            end

            assign to_hit_c = (state_q == REQ) && !mem_ready &&
                              (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timeout
            assign to_hit_c = 1'b0;
        end
    endgenerate

    // Next-state and next-output logic; faults detected at start skip the bus entirely.
    always_comb begin
        state_d = state_q;
        latch_c = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cause_d = ERR_NONE;
        req_d   = 1'b0;
        wr_d    = 1'b0;
        wsel_d  = wsel_q;
        wdat_d  = wdat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    latch_c = 1'b1;
                    if (!f3_legal(is_store, funct3)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        cause_d = ERR_ILLEGAL;
                    end else if (f3_misaligned(funct3, ea_c[1:0])) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        cause_d = ERR_MISALIGN;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    if (!st_q) begin
                        wsel_d = rd_q;
                        wdat_d = al_load;
                        wr_d   = (rd_q != 5'd0);
                    end
                end else if (to_hit_c) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    cause_d = ERR_TIMEOUT;
                end else begin
                    req_d = 1'b1;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, output and operand registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cause_q <= ERR_NONE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            wsel_q  <= 5'd0;
            wdat_q  <= 32'h0;
            ea_q    <= 32'h0;
            sdata_q <= 32'h0;
            f3_q    <= 3'b000;
            st_q    <= 1'b0;
            rd_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cause_q <= cause_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            wsel_q  <= wsel_d;
            wdat_q  <= wdat_d;
            if (latch_c) begin
                ea_q    <= ea_c;
                sdata_q <= store_data;
                f3_q    <= funct3;
                st_q    <= is_store;
                rd_q    <= rd;
            end
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = err_q;
    assign error_cause       = cause_q;
    assign mem_req           = req_q;
    assign mem_we            = req_q & st_q;
    assign mem_addr          = {ea_q[31:2], 2'b00};
    assign mem_wdata         = al_wdata;
    assign mem_wstrb         = st_q ? al_wstrb : 4'b0000;
    assign reg_write_control = wr_q;
    assign reg_write_select  = wsel_q;
    assign reg_write_data    = wdat_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed ops push expectations, a negedge monitor checks them.
module tb_load_store_unit;

    typedef struct packed {
        logic [7:0]  lat;
        logic        err;
        logic [1:0]  cause;
        logic        wr;
        logic [4:0]  sel;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [4:0]  rd = 5'd0;
    logic [31:0] base = 32'h0;
    logic [31:0] offset = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        busy, done, error, mem_req, mem_we, reg_write_control;
    logic [1:0]  error_cause;
    logic [31:0] mem_addr, mem_wdata, reg_write_data;
    logic [3:0]  mem_wstrb;
    logic [4:0]  reg_write_select;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .is_store          (is_store),
        .funct3            (funct3),
        .rd                (rd),
        .base              (base),
        .offset            (offset),
        .store_data        (store_data),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .error_cause       (error_cause),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_wstrb         (mem_wstrb),
        .mem_ready         (mem_ready),
        .mem_rdata         (mem_rdata),
        .reg_write_control (reg_write_control),
        .reg_write_select  (reg_write_select),
        .reg_write_data    (reg_write_data)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   start_cyc = 0;
    int   req_cnt = 0;
    int   n_pass = 0;
    int   n_tot = 0;
    exp_t exp_q[$];
    bus_t bus_q[$];
    string       nm_q[$];
    logic [31:0] act_q[$];
    logic [31:0] req_q[$];
    exp_t em;
    bus_t bm;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_tot++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, a, e);
    endtask

    // Monitor: bus handshakes, retirements and queued stimulus-side checks.
    always @(negedge clk) begin
        if (mem_req) req_cnt++;
        if (mem_req && mem_ready) begin
            if (bus_q.size() == 0) chk("unexpected_bus", 32'd1, 32'd0);
            else begin
                bm = bus_q.pop_front();
                chk("mem_we", 32'(mem_we), 32'(bm.we));
                chk("mem_addr", mem_addr, bm.addr);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(bm.wstrb));
                if (bm.we) chk("mem_wdata", mem_wdata, bm.wdata);
            end
        end
        if (done) begin
            if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else begin
                em = exp_q.pop_front();
                chk("latency", 32'(cyc - start_cyc), 32'(em.lat));
                chk("error", 32'(error), 32'(em.err));
                if (em.err) chk("error_cause", 32'(error_cause), 32'(em.cause));
                chk("reg_we", 32'(reg_write_control), 32'(em.wr));
                if (em.wr) begin
                    chk("reg_sel", 32'(reg_write_select), 32'(em.sel));
                    chk("reg_data", reg_write_data, em.data);
                end
            end
        end
        while (nm_q.size() > 0) chk(nm_q.pop_front(), act_q.pop_front(), req_q.pop_front());
    end

    task automatic post(input string nm, input logic [31:0] a, input logic [31:0] e);
        nm_q.push_back(nm);
        act_q.push_back(a);
        req_q.push_back(e);
    endtask

    // Issue one op, answer the bus after k cycles (0 = never), optionally poke start while busy.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [4:0] r,
                          input logic [31:0] b, input logic [31:0] o, input logic [31:0] sd,
                          input logic [31:0] rdat, input int k, input bit poke,
                          input exp_t e, input bit bv, input bus_t bx);
        int req0;
        bit fin;
        @(posedge clk); #1;
        is_store = st; funct3 = f3; rd = r; base = b; offset = o; store_data = sd;
        start = 1'b1;
        start_cyc = cyc;
        req0 = req_cnt;
        exp_q.push_back(e);
        if (bv) bus_q.push_back(bx);
        @(posedge clk); #1;
        start = poke;
        if (poke) begin is_store = 1'b0; funct3 = 3'b011; end
        fin = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c == k) begin mem_ready = 1'b1; mem_rdata = rdat; end
            @(posedge clk); #1;
            mem_ready = 1'b0;
            start = 1'b0;
            if (exp_q.size() == 0) begin fin = 1'b1; break; end
        end
        if (!fin) begin
            post("done_timeout", 32'd1, 32'd0);
            exp_q.delete();
            bus_q.delete();
        end
        if (e.err && e.cause != 2'b11) post("no_req_on_fault", 32'(req_cnt - req0), 32'd0);
        if (e.err && e.cause == 2'b11) post("timeout_req_cycles", 32'(req_cnt - req0), 32'd4);
    endtask

    localparam bus_t NB = '{1'b0, 32'h0, 32'h0, 4'h0};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        post("rst_busy", 32'(busy), 32'd0);
        post("rst_done", 32'(done), 32'd0);
        post("rst_error", 32'(error), 32'd0);
        post("rst_cause", 32'(error_cause), 32'd0);
        post("rst_mem_req", 32'(mem_req), 32'd0);
        post("rst_mem_we", 32'(mem_we), 32'd0);
        post("rst_mem_addr", mem_addr, 32'd0);
        post("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        post("rst_reg_we", 32'(reg_write_control), 32'd0);
        post("rst_reg_data", reg_write_data, 32'd0);
        reset = 1'b0;

        // SW, ready at cycle 3
        run_op(1'b1, 3'b010, 5'd0, 32'h100, 32'd4, 32'hDEADBEEF, 32'h0, 3, 1'b0,
               '{8'd4, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0}, 1'b1, '{1'b1, 32'h104, 32'hDEADBEEF, 4'hF});
        // LB byte 3, sign-extended
        run_op(1'b0, 3'b000, 5'd5, 32'h200, 32'd3, 32'h0, 32'h80FFFF7F, 1, 1'b0,
               '{8'd2, 1'b0, 2'd0, 1'b1, 5'd5, 32'hFFFFFF80}, 1'b1, '{1'b0, 32'h200, 32'h0, 4'h0});
        // LHU upper half
        run_op(1'b0, 3'b101, 5'd6, 32'h200, 32'd2, 32'h0, 32'hBEEF1234, 2, 1'b0,
               '{8'd3, 1'b0, 2'd0, 1'b1, 5'd6, 32'h0000BEEF}, 1'b1, '{1'b0, 32'h200, 32'h0, 4'h0});
        // LH upper half, sign-extended
        run_op(1'b0, 3'b001, 5'd7, 32'h200, 32'd2, 32'h0, 32'hBEEF1234, 1, 1'b0,
               '{8'd2, 1'b0, 2'd0, 1'b1, 5'd7, 32'hFFFFBEEF}, 1'b1, '{1'b0, 32'h200, 32'h0, 4'h0});
        // LBU byte 1, zero-extended
        run_op(1'b0, 3'b100, 5'd8, 32'h600, 32'd1, 32'h0, 32'h123480FF, 1, 1'b0,
               '{8'd2, 1'b0, 2'd0, 1'b1, 5'd8, 32'h00000080}, 1'b1, '{1'b0, 32'h600, 32'h0, 4'h0});
        // LB byte 0, positive
        run_op(1'b0, 3'b000, 5'd11, 32'h800, 32'd0, 32'h0, 32'hAAAA807F, 1, 1'b0,
               '{8'd2, 1'b0, 2'd0, 1'b1, 5'd11, 32'h0000007F}, 1'b1, '{1'b0, 32'h800, 32'h0, 4'h0});
        // SB lane 3
        run_op(1'b1, 3'b000, 5'd0, 32'h500, 32'd3, 32'h11223344, 32'h0, 1, 1'b0,
               '{8'd2, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0}, 1'b1, '{1'b1, 32'h500, 32'h44444444, 4'h8});
        // SH upper half
        run_op(1'b1, 3'b001, 5'd0, 32'h500, 32'd2, 32'hAABBCCDD, 32'h0, 2, 1'b0,
               '{8'd3, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0}, 1'b1, '{1'b1, 32'h500, 32'hCCDDCCDD, 4'hC});
        // SH misaligned
        run_op(1'b1, 3'b001, 5'd0, 32'h300, 32'd1, 32'h0, 32'h0, 0, 1'b0,
               '{8'd1, 1'b1, 2'b01, 1'b0, 5'd0, 32'h0}, 1'b0, NB);
        // Load funct3=011 at an odd address: illegal wins over misaligned
        run_op(1'b0, 3'b011, 5'd4, 32'h301, 32'd0, 32'h0, 32'h0, 0, 1'b0,
               '{8'd1, 1'b1, 2'b10, 1'b0, 5'd0, 32'h0}, 1'b0, NB);
        // Store with BU encoding is illegal
        run_op(1'b1, 3'b100, 5'd0, 32'h300, 32'd0, 32'h0, 32'h0, 0, 1'b0,
               '{8'd1, 1'b1, 2'b10, 1'b0, 5'd0, 32'h0}, 1'b0, NB);
        // LW misaligned
        run_op(1'b0, 3'b010, 5'd4, 32'h302, 32'd0, 32'h0, 32'h0, 0, 1'b0,
               '{8'd1, 1'b1, 2'b01, 1'b0, 5'd0, 32'h0}, 1'b0, NB);
        // LW timeout after 4 request cycles
        run_op(1'b0, 3'b010, 5'd3, 32'h400, 32'd0, 32'h0, 32'h0, 0, 1'b0,
               '{8'd5, 1'b1, 2'b11, 1'b0, 5'd0, 32'h0}, 1'b0, NB);
        // LW to x0: no writeback
        run_op(1'b0, 3'b010, 5'd0, 32'h10, 32'd0, 32'h0, 32'h12345678, 1, 1'b0,
               '{8'd2, 1'b0, 2'd0, 1'b0, 5'd0, 32'h0}, 1'b1, '{1'b0, 32'h10, 32'h0, 4'h0});
        // Address wrap-around
        run_op(1'b0, 3'b010, 5'd9, 32'hFFFFFFFC, 32'd8, 32'h0, 32'hCAFEF00D, 1, 1'b0,
               '{8'd2, 1'b0, 2'd0, 1'b1, 5'd9, 32'hCAFEF00D}, 1'b1, '{1'b0, 32'h4, 32'h0, 4'h0});
        // start while busy is ignored
        run_op(1'b0, 3'b010, 5'd10, 32'h700, 32'd0, 32'h0, 32'h00000001, 3, 1'b1,
               '{8'd4, 1'b0, 2'd0, 1'b1, 5'd10, 32'h00000001}, 1'b1, '{1'b0, 32'h700, 32'h0, 4'h0});

        // Reset while in REQ abandons the op
        @(posedge clk); #1;
        is_store = 1'b0; funct3 = 3'b010; rd = 5'd12; base = 32'h900; offset = 32'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        post("pre_reset_mem_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        post("mid_reset_mem_req", 32'(mem_req), 32'd0);
        post("mid_reset_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        post("exp_q_empty", 32'(exp_q.size()), 32'd0);
        post("bus_q_empty", 32'(bus_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
